ws2811_driver: RTL and testbench
================================

# ws2811_driver

Serialises per-LED colour from the LED controller onto a single WS2811 data line, one frame at a time. The driver walks `ledindex` from 0 to NUM_LEDS-1, captures the colour the controller returns, and shifts 24 bits per LED with WS2811 pulse-width encoding. A latch/reset gap separates consecutive frames. It sits directly downstream of the LED controller and drives the strip pin.

## Interface
Parameters:
- NUM_LEDS, 49, LEDs in the string (1..256)
- T0H, 20, high time of a 0 bit, in clk cycles
- T1H, 40, high time of a 1 bit, in clk cycles (T0H < T1H < TBIT)
- TBIT, 62, total bit period, in clk cycles
- TRESET, 2500, minimum low time between frames, in clk cycles
- FETCH_LAT, 2, cycles from a `ledindex` change to valid red/green/blue (controller register plus margin, ≥1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  start new frames while high
- ledindex  out  8  index of the LED whose colour is being fetched
- red  in  8  colour from controller for `ledindex`
- green  in  8  colour from controller for `ledindex`
- blue  in  8  colour from controller for `ledindex`
- data_out  out  1  WS2811 serial data, registered
- busy  out  1  high while a frame's bits are being sent
- frame_start  out  1  one-cycle pulse on the first cycle of bit 0 of LED 0

## Operation
- One clock and one reset. The reset is asynchronous and active-high.
- States:
  - GAP: `data_out` is 0 while a counter runs TRESET cycles.
  - IDLE: waits for `enable`.
  - PREFETCH: waits FETCH_LAT cycles, then captures colour.
  - SEND: shifts bits.
- GAP entry:
  - `ledindex` is set to 0.
  - When the counter reaches TRESET-1: if `enable` is 1, go to PREFETCH; otherwise go to IDLE.
- IDLE: when `enable` is 1, go to PREFETCH. `data_out` stays 0.
- PREFETCH: waits FETCH_LAT cycles after `ledindex`=0. It then loads {red, green, blue} into the shift register and enters SEND.
- Shift order: red MSB first, then green, then blue. 24 bits per LED.
- Bit encoding:
  - A bit counter runs 0..TBIT-1.
  - `data_out` is 1 while counter < T1H for a 1 bit, or < T0H for a 0 bit. It is 0 for the rest of the period.
- Gap-free prefetch:
  - When LED k loads into the shift register, `ledindex` advances to k+1 if k < NUM_LEDS-1.
  - FETCH_LAT cycles later, the colour is captured into a 24-bit holding register.
  - At the end of bit 23 of LED k, the holding register loads into the shift register. There is no idle cycle between LEDs.
- After bit 23 of LED NUM_LEDS-1, go to GAP.
- `enable` is sampled only at the GAP exit and in IDLE. Deasserting it mid-frame lets the frame complete.
- `ledindex` never exceeds NUM_LEDS-1. It holds its last value during the tail of the final LED.
- Widths:
  - The bit-timer counter holds TBIT-1.
  - The gap counter holds TRESET-1.
  - The LED counter is 8 bits.
  - The bit counter is 5 bits.

## Timing
- Reset values: `data_out`=0, `ledindex`=0, `busy`=0, `frame_start`=0, state=GAP with counter 0.
- Reset asserted mid-frame: `data_out` goes to 0 immediately (asynchronously). After release, a full TRESET gap runs before any new frame.
- Frame length: exactly 24·NUM_LEDS·TBIT cycles from `frame_start` to GAP entry.
- Frame-to-frame period with `enable` held high: TRESET + FETCH_LAT + 24·NUM_LEDS·TBIT cycles.
- `data_out` is registered:
  - Its rising edge is coincident with bit-counter value 0.
  - `frame_start` and the first `data_out` high occur in the same cycle.
- `busy` is 1 from `frame_start` through the last cycle of the final bit. It is 0 in GAP, IDLE and PREFETCH.
- Colour must be stable from FETCH_LAT cycles after a `ledindex` change until capture. The driver does not re-sample.

## Test plan
- NUM_LEDS=1, stub returns R=FF, G=00, B=00 -> 8 pulses of 40 cycles high / 22 low, then 16 pulses of 20 high / 42 low, then `data_out` low ≥2500 cycles.
- NUM_LEDS=4, stub returns red=ledindex·17, green=~red, blue=A5 with 1-cycle latency -> decoded stream matches per LED; `ledindex` steps 0,1,2,3; no extra cycles between LEDs (96 bits contiguous).
- `enable`=0 out of reset -> `data_out`=0, `busy`=0 indefinitely. Raising `enable` -> `frame_start` FETCH_LAT+1 cycles later.
- Deassert `enable` during LED 2 of 4 -> frame finishes all 96 bits, then GAP, then IDLE with no further `frame_start`.
- Assert `reset` mid-bit while `data_out`=1 -> `data_out`=0 in the same cycle. After release, ≥2500 low cycles precede the next `frame_start`.
- `enable` held high, NUM_LEDS=2 -> `frame_start` period exactly TRESET + FETCH_LAT + 48·TBIT = 5478 cycles.

Source files
------------

// File: rtl/ws2811_driver.sv
// ws2811_driver: walks the LED controller's colour table one LED at a time
// and serialises 24 bits per LED (red, green, blue, MSB first) onto a single
// WS2811 data line using pulse-width encoding, with a low latch gap between
// consecutive frames. The next LED's colour is prefetched into a holding
// register while the current LED shifts, so LEDs follow back to back.
module ws2811_driver #(
  parameter int NUM_LEDS  = 49,
  parameter int T0H       = 20,
  parameter int T1H       = 40,
  parameter int TBIT      = 62,
  parameter int TRESET    = 2500,
  parameter int FETCH_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic [7:0] ledindex,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  output logic       data_out,
  output logic       busy,
  output logic       frame_start
);

  localparam int TW = (TBIT > 1) ? $clog2(TBIT) : 1;
  localparam int GW = (TRESET > 1) ? $clog2(TRESET) : 1;
  localparam int FW = $clog2(FETCH_LAT + 1);

  localparam logic [1:0] ST_GAP      = 2'd0;
  localparam logic [1:0] ST_IDLE     = 2'd1;
  localparam logic [1:0] ST_PREFETCH = 2'd2;
  localparam logic [1:0] ST_SEND     = 2'd3;

  localparam logic [TW-1:0] TBIT_LAST = TW'(TBIT - 1);
  localparam logic [TW-1:0] T0H_W     = TW'(T0H);
  localparam logic [TW-1:0] T1H_W     = TW'(T1H);
  localparam logic [GW-1:0] GAP_LAST  = GW'(TRESET - 1);
  localparam logic [FW-1:0] PF_LAST   = FW'(FETCH_LAT - 1);
  localparam logic [FW-1:0] FETCH_AT  = FW'(FETCH_LAT);
  localparam logic [7:0]    LED_LAST  = 8'(NUM_LEDS - 1);
  localparam logic [4:0]    BIT_LAST  = 5'd23;

  logic [1:0]    state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [4:0]    bit_q, bit_d;
  logic [7:0]    led_q, led_d;
  logic [7:0]    idx_q, idx_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fpend_q, fpend_d;
  logic [23:0]   shift_q, shift_d;
  logic [23:0]   hold_q, hold_d;
  logic          data_out_q, data_out_d;
  logic          busy_q, busy_d;
  logic          frame_start_q, frame_start_d;

  // Next-state logic for the frame sequencer, bit timer and prefetch path.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    tcnt_d  = tcnt_q;
    bit_d   = bit_q;
    led_d   = led_q;
    idx_d   = idx_q;
    fcnt_d  = fcnt_q;
    fpend_d = fpend_q;
    shift_d = shift_q;
    hold_d  = hold_q;

    case (state_q)
      ST_GAP: begin
        idx_d = '0;
        if (gap_q == GAP_LAST) begin
          gap_d = '0;
          if (enable) begin
            state_d = ST_PREFETCH;
            fcnt_d  = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      ST_IDLE: begin
        if (enable) begin
          state_d = ST_PREFETCH;
          fcnt_d  = '0;
        end
      end

      ST_PREFETCH: begin
        if (fcnt_q == PF_LAST) begin
          state_d = ST_SEND;
          shift_d = {red, green, blue};
          tcnt_d  = '0;
          bit_d   = '0;
          led_d   = '0;
          fcnt_d  = '0;
          fpend_d = 1'b0;
          // Loading LED 0 immediately points the controller at LED 1.
          if (idx_q < LED_LAST) begin
            idx_d   = idx_q + 8'd1;
            fpend_d = 1'b1;
          end
        end else begin
          fcnt_d = fcnt_q + FW'(1);
        end
      end

      ST_SEND: begin
        // Capture the next LED's colour once the controller has had
        // FETCH_LAT cycles to respond to the ledindex change.
        if (fpend_q) begin
          if (fcnt_q == FETCH_AT) begin
            hold_d  = {red, green, blue};
            fpend_d = 1'b0;
          end else begin
            fcnt_d = fcnt_q + FW'(1);
          end
        end

        if (tcnt_q == TBIT_LAST) begin
          tcnt_d = '0;
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
            if (led_q == LED_LAST) begin
              state_d = ST_GAP;
              gap_d   = '0;
              idx_d   = '0;
              fpend_d = 1'b0;
            end else begin
              led_d   = led_q + 8'd1;
              shift_d = hold_q;
              if (idx_q < LED_LAST) begin
                idx_d   = idx_q + 8'd1;
                fcnt_d  = '0;
                fpend_d = 1'b1;
              end
            end
          end else begin
            bit_d   = bit_q + 5'd1;
            shift_d = {shift_q[22:0], 1'b0};
          end
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end

      default: begin
        state_d = ST_GAP;
        gap_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from next-state values so that the registered
  // data_out rises on the same cycle the bit timer reads 0.
  always_comb begin
    data_out_d    = (state_d == ST_SEND) &&
                    (tcnt_d < (shift_d[23] ? T1H_W : T0H_W));
    busy_d        = (state_d == ST_SEND);
    frame_start_d = (state_q == ST_PREFETCH) && (state_d == ST_SEND);
  end

  // State and output registers; reset forces the line low at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_GAP;
      gap_q         <= '0;
      tcnt_q        <= '0;
      bit_q         <= '0;
      led_q         <= '0;
      idx_q         <= '0;
      fcnt_q        <= '0;
      fpend_q       <= 1'b0;
      shift_q       <= '0;
      hold_q        <= '0;
      data_out_q    <= 1'b0;
      busy_q        <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      gap_q         <= gap_d;
      tcnt_q        <= tcnt_d;
      bit_q         <= bit_d;
      led_q         <= led_d;
      idx_q         <= idx_d;
      fcnt_q        <= fcnt_d;
      fpend_q       <= fpend_d;
      shift_q       <= shift_d;
      hold_q        <= hold_d;
      data_out_q    <= data_out_d;
      busy_q        <= busy_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign ledindex    = idx_q;
  assign data_out    = data_out_q;
  assign busy        = busy_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_ws2811_driver.sv
// tb_ws2811_driver: drives ws2811_driver with a registered colour-table stub
// and compares every cycle of each frame and gap against waveforms computed
// arithmetically from the colour table and the bit-timing parameters.
module tb_ws2811_driver;

  localparam int NUM_LEDS  = 4;
  localparam int T0H       = 20;
  localparam int T1H       = 40;
  localparam int TBIT      = 62;
  localparam int TRESET    = 2500;
  localparam int FETCH_LAT = 2;
  localparam int LED_CYC   = 24 * TBIT;
  localparam int FRAME     = NUM_LEDS * LED_CYC;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] ledindex;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic       data_out;
  logic       busy;
  logic       frame_start;

  logic [23:0] tbl [NUM_LEDS];
  logic [23:0] stub_q;

  int checks   = 0;
  int failures = 0;

  ws2811_driver #(
    .NUM_LEDS (NUM_LEDS),
    .T0H      (T0H),
    .T1H      (T1H),
    .TBIT     (TBIT),
    .TRESET   (TRESET),
    .FETCH_LAT(FETCH_LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .ledindex   (ledindex),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .data_out   (data_out),
    .busy       (busy),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Controller stub: one register of latency from ledindex to colour.
  always @(posedge clk) begin
    if (int'(ledindex) < NUM_LEDS) stub_q <= tbl[int'(ledindex)];
    else stub_q <= 24'hBAD0BA;
  end

  assign red   = stub_q[23:16];
  assign green = stub_q[15:8];
  assign blue  = stub_q[7:0];

  task automatic fill_pattern();
    logic [7:0] r;
    for (int i = 0; i < NUM_LEDS; i++) begin
      r = 8'(i * 17);
      tbl[i] = {r, ~r, 8'hA5};
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < NUM_LEDS; i++) tbl[i] = 24'($urandom);
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    enable = 1'b0;
    fill_pattern();
    repeat (3) @(negedge clk);
    checks++;
    if (data_out !== 1'b0) begin failures++; $display("FAIL reset_data_out got %b want 0", data_out); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (frame_start !== 1'b0) begin failures++; $display("FAIL reset_frame_start got %b want 0", frame_start); end
    checks++;
    if (ledindex !== 8'd0) begin failures++; $display("FAIL reset_ledindex got %0d want 0", ledindex); end
    reset = 1'b0;
  endtask

  task automatic test_idle_then_enable();
    int active;
    int k;
    active = 0;
    for (int i = 0; i < 3000; i++) begin
      if (data_out !== 1'b0 || busy !== 1'b0 || frame_start !== 1'b0) active++;
      @(negedge clk);
    end
    checks++;
    if (active != 0) begin
      failures++;
      $display("FAIL idle_quiet got %0d active cycles want 0", active);
    end
    enable = 1'b1;
    k = 0;
    while (frame_start !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k != FETCH_LAT + 1) begin
      failures++;
      $display("FAIL enable_latency got %0d cycles want %0d", k, FETCH_LAT + 1);
    end
  endtask

  // Checks one full frame plus the following latch gap, cycle by cycle.
  task automatic test_frame_stream(input logic started, input int drop_at,
                                   input bit rerand, input string name);
    logic [23:0] exp_tbl [NUM_LEDS];
    int k, led, bi, ph, ei;
    int err_d, err_b, err_i, err_f;
    int t_d, t_b, t_i, t_f;
    logic ed, eb, ef, bv, got_d;
    logic [7:0] got_i;
    if (started !== 1'b1) begin
      k = 0;
      while (frame_start !== 1'b1 && k < FRAME + TRESET + 100) begin
        @(negedge clk);
        k++;
      end
    end
    checks++;
    if (frame_start !== 1'b1) begin
      failures++;
      $display("FAIL %s start_timeout got frame_start=%b want 1", name, frame_start);
      return;
    end
    exp_tbl = tbl;
    err_d = 0; err_b = 0; err_i = 0; err_f = 0;
    t_d = 0; t_b = 0; t_i = 0; t_f = 0;
    got_d = 1'b0; got_i = 8'd0;
    for (int t = 0; t < FRAME + TRESET; t++) begin
      if (t < FRAME) begin
        led = t / LED_CYC;
        bi  = (t / TBIT) % 24;
        ph  = t % TBIT;
        bv  = exp_tbl[led][23 - bi];
        ed  = (ph < (bv ? T1H : T0H));
        eb  = 1'b1;
        ei  = (led + 1 < NUM_LEDS) ? led + 1 : NUM_LEDS - 1;
      end else begin
        ed = 1'b0;
        eb = 1'b0;
        ei = 0;
      end
      ef = (t == 0);
      if (data_out !== ed) begin
        if (err_d == 0) begin t_d = t; got_d = data_out; end
        err_d++;
      end
      if (busy !== eb) begin
        if (err_b == 0) t_b = t;
        err_b++;
      end
      if (ledindex !== 8'(ei)) begin
        if (err_i == 0) begin t_i = t; got_i = ledindex; end
        err_i++;
      end
      if (frame_start !== ef) begin
        if (err_f == 0) t_f = t;
        err_f++;
      end
      if (t == drop_at) enable = 1'b0;
      if (rerand && t == FRAME + TRESET / 2) fill_random();
      @(negedge clk);
    end
    checks++;
    if (err_d != 0) begin
      failures++;
      $display("FAIL %s data_out: %0d bad cycles, first t=%0d got %b want %b",
               name, err_d, t_d, got_d, ~got_d);
    end
    checks++;
    if (err_b != 0) begin
      failures++;
      $display("FAIL %s busy: %0d bad cycles, first t=%0d got %b want %b",
               name, err_b, t_b, (t_b < FRAME) ? 1'b0 : 1'b1, (t_b < FRAME) ? 1'b1 : 1'b0);
    end
    checks++;
    if (err_i != 0) begin
      failures++;
      $display("FAIL %s ledindex: %0d bad cycles, first t=%0d got %0d want %0d",
               name, err_i, t_i, got_i,
               (t_i < FRAME) ? ((t_i / LED_CYC + 1 < NUM_LEDS) ? t_i / LED_CYC + 1 : NUM_LEDS - 1) : 0);
    end
    checks++;
    if (err_f != 0) begin
      failures++;
      $display("FAIL %s frame_start: %0d bad cycles, first t=%0d got %b want %b",
               name, err_f, t_f, (t_f == 0) ? 1'b0 : 1'b1, (t_f == 0) ? 1'b1 : 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    k = 0;
    while (frame_start !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k != FETCH_LAT) begin
      failures++;
      $display("FAIL back_to_back_period got %0d want %0d",
               FRAME + TRESET + k, FRAME + TRESET + FETCH_LAT);
    end
  endtask

  task automatic test_drop_idle();
    int active;
    active = 0;
    for (int i = 0; i < 3000; i++) begin
      if (data_out !== 1'b0 || busy !== 1'b0 || frame_start !== 1'b0 || ledindex !== 8'd0)
        active++;
      @(negedge clk);
    end
    checks++;
    if (active != 0) begin
      failures++;
      $display("FAIL drop_idle got %0d active cycles want 0", active);
    end
  endtask

  task automatic test_reset_mid_frame();
    int k;
    int bad;
    enable = 1'b1;
    k = 0;
    while (frame_start !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (frame_start !== 1'b1) begin
      failures++;
      $display("FAIL rst_start got frame_start=%b want 1", frame_start);
    end
    repeat (5 * TBIT + 3) @(negedge clk);
    checks++;
    if (data_out !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre_high got %b want 1", data_out);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (data_out !== 1'b0) begin
      failures++;
      $display("FAIL rst_async_data_out got %b want 0", data_out);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_async_busy got %b want 0", busy);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    k = 0;
    bad = 0;
    while (frame_start !== 1'b1 && k < TRESET + 50) begin
      if (data_out !== 1'b0) bad++;
      @(negedge clk);
      k++;
    end
    checks++;
    if (k < TRESET || k > TRESET + FETCH_LAT + 2 || bad != 0) begin
      failures++;
      $display("FAIL rst_gap got %0d cycles (%0d high) want %0d..%0d cycles all low",
               k, bad, TRESET, TRESET + FETCH_LAT + 2);
    end
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    test_reset();
    test_idle_then_enable();
    test_frame_stream(frame_start, -1, 1'b1, "pattern");
    test_back_to_back();
    test_frame_stream(frame_start, -1, 1'b1, "random1");
    test_back_to_back();
    test_frame_stream(frame_start, 2 * LED_CYC + 50, 1'b1, "drop");
    test_drop_idle();
    test_reset_mid_frame();
    test_frame_stream(frame_start, -1, 1'b0, "post_reset");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
